reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 64-bit register file directly upstream of the execute-stage ALU in the single-cycle datapath.
- Two combinational read ports drive the ALU A and B operands.
- One synchronous write port accepts the writeback result.
- Register X31 reads as zero (XZR).

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH must equal NUM_REGS.
- ZERO_REG, 31, index hardwired to read zero; writes to it are discarded.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ReadRegister1  input  ADDR_WIDTH  index for read port 1 (ALU A operand).
- ReadRegister2  input  ADDR_WIDTH  index for read port 2 (ALU B operand).
- WriteRegister  input  ADDR_WIDTH  index for the write port.
- WriteData  input  DATA_WIDTH  value to write.
- RegWrite  input  1  write enable.
- ReadData1  output  DATA_WIDTH  contents of ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of ReadRegister2.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset:
  - When reset is sampled high at a rising edge, all NUM_REGS registers become 0 at that edge.
  - A write presented in the same cycle is discarded; reset has priority over RegWrite.
  - After the reset edge, ReadData1 and ReadData2 read 0 for every index.
  - Before the first reset edge, register contents are undefined. Reads of ZERO_REG are still 0.
- Write:
  - At a rising edge with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData.
  - The new value is visible on the read ports after that edge (within the same settle window as any combinational read).
  - RegWrite=0: no register changes.
  - WriteRegister==ZERO_REG: the write is ignored and no storage changes.
- Read:
  - Fully combinational, zero-cycle latency. ReadDataN = register[ReadRegisterN].
  - If ReadRegisterN==ZERO_REG, ReadDataN = 0 regardless of stored state or pending write.
  - Both ports are independent; both may address the same index.
- Read-during-write (same cycle, same index, RegWrite=1, index != ZERO_REG):
  - Default (no macro): the read port returns the old stored value until the edge, then the new value.
- Write decode:
  - Exactly one register enable asserts per active write (one-hot decode of WriteRegister gated by RegWrite).
  - Zero enables assert when RegWrite=0, when reset=1, or when the target is ZERO_REG.
- Read mux: each port uses a NUM_REGS:1 DATA_WIDTH-wide mux, with the ZERO_REG input tied to 0.
- Storage: DATA_WIDTH x NUM_REGS D flip-flops, each with a synchronous reset and enable (hold when not enabled).
- No X propagation out of ZERO_REG under any input state.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding.
  - If RegWrite=1, reset=0, WriteRegister==ReadRegisterN and WriteRegister!=ZERO_REG, then ReadDataN = WriteData combinationally within the same cycle.
  - Otherwise reads behave as the default.
  - reset=1 suppresses forwarding: ReadDataN shows stored contents.
- Undefined:
  - No forwarding logic is compiled.
  - Read-during-write returns the old value as described under Behaviour.

Test Plan:
- Reset clearing: write 0xDEADBEEF_CAFEF00D to X5, then assert reset for 1 cycle -> ReadData1 with ReadRegister1=5 reads 0. All indices 0..31 read 0.
- Write then read on both ports: RegWrite=1, write 0x0123456789ABCDEF to X0 and 0xFFFFFFFFFFFFFFFF to X30 on successive edges, RegWrite=0 -> ReadData1(X0)=0x0123456789ABCDEF, ReadData2(X30)=0xFFFFFFFFFFFFFFFF. Both ports reading X30 simultaneously return the same value.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=0xAAAA... -> ReadData1(X31)=0 and ReadData2(X31)=0. All other registers are unchanged (scan 0..30).
- Write enable low: X7 holds 0x55, then RegWrite=0, WriteRegister=7, WriteData=0x99 for 3 edges -> X7 still reads 0x55.
- Reset vs write collision: reset=1, RegWrite=1, WriteRegister=3, WriteData=0x77 on the same edge -> X3 reads 0 after the edge.
- Read-during-write: X9=0x10, then a same-cycle write of 0x20 to X9 with ReadRegister1=9:
  - Without REG_FILE_BYPASS_EN: ReadData1=0x10 before the edge, 0x20 after.
  - With REG_FILE_BYPASS_EN: ReadData1=0x20 before the edge.
  - Repeat the same check with index 31 -> ReadData1=0 in both builds.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous write port, X31 reads zero.
// Optional macro REG_FILE_BYPASS_EN adds same-cycle write-to-read forwarding on both read ports.
module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    if (2 ** ADDR_WIDTH != NUM_REGS) begin : g_bad_params
        $error("reg_file: 2**ADDR_WIDTH must equal NUM_REGS");
    end

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_en;

    // One-hot write decode; reset and the zero register suppress every enable.
    always_comb begin
        // NOTE: default first so no path through this block leaves wr_en unassigned (no latch).
        wr_en = '0;
        if (RegWrite && !reset && (WriteRegister != ZERO_IDX)) begin
            wr_en[WriteRegister] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array is reset on purpose; every architectural register must read 0 after reset,
        // which rules out a RAM macro but matches the flop-based storage this block calls for.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] rd;
        if (addr == ZERO_IDX) begin
            rd = '0;
        end else begin
            rd = regs_q[addr];
`ifdef REG_FILE_BYPASS_EN
            if (RegWrite && !reset && (WriteRegister == addr)) begin
                rd = WriteData;
            end
`endif
        end
        return rd;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadRegister1);
        ReadData2 = read_port(ReadRegister2);
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1, ReadData2;

    int passed = 0;
    int total  = 0;

    reg_file dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = addr;
        WriteData     = data;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
    endtask

    task automatic test_pre_reset_zero();
        set_reads(5'd31, 5'd31);
        total++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0)
            $display("FAIL pre_reset_x31: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
        else passed++;
    endtask

    task automatic test_reset();
        write_reg(5'd5, 64'hDEADBEEF_CAFEF00D);
        set_reads(5'd5, 5'd5);
        total++;
        if (ReadData1 !== 64'hDEADBEEF_CAFEF00D)
            $display("FAIL reset_prewrite_x5: got %h expected deadbeefcafef00d", ReadData1);
        else passed++;
        pulse_reset();
        set_reads(5'd5, 5'd5);
        total++;
        if (ReadData1 !== 64'h0)
            $display("FAIL reset_x5: got %h expected 0", ReadData1);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            set_reads(5'(i), 5'(31 - i));
            total++;
            if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0)
                $display("FAIL reset_scan[%0d]: rd1=%h rd2=%h expected 0", i, ReadData1, ReadData2);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd0,  64'h0123456789ABCDEF);
        write_reg(5'd30, 64'hFFFFFFFFFFFFFFFF);
        set_reads(5'd0, 5'd30);
        total++;
        if (ReadData1 !== 64'h0123456789ABCDEF)
            $display("FAIL write_read_x0: got %h expected 0123456789abcdef", ReadData1);
        else passed++;
        total++;
        if (ReadData2 !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL write_read_x30: got %h expected ffffffffffffffff", ReadData2);
        else passed++;
        set_reads(5'd30, 5'd30);
        total++;
        if (ReadData1 !== 64'hFFFFFFFFFFFFFFFF || ReadData2 !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL both_ports_x30: rd1=%h rd2=%h expected ffffffffffffffff", ReadData1, ReadData2);
        else passed++;
    endtask

    task automatic test_zero_reg();
        for (int i = 0; i < 31; i++) write_reg(5'(i), 64'h1111_2222_0000_0000 + 64'(i));
        write_reg(5'd31, 64'hAAAAAAAAAAAAAAAA);
        set_reads(5'd31, 5'd31);
        total++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0)
            $display("FAIL zero_reg_x31: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
        else passed++;
        for (int i = 0; i < 31; i++) begin
            set_reads(5'(i), 5'(30 - i));
            total++;
            if (ReadData1 !== 64'h1111_2222_0000_0000 + 64'(i) ||
                ReadData2 !== 64'h1111_2222_0000_0000 + 64'(30 - i))
                $display("FAIL zero_reg_scan[%0d]: rd1=%h rd2=%h expected %h/%h", i, ReadData1,
                         ReadData2, 64'h1111_2222_0000_0000 + 64'(i),
                         64'h1111_2222_0000_0000 + 64'(30 - i));
            else passed++;
        end
    endtask

    task automatic test_write_enable_low();
        write_reg(5'd7, 64'h55);
        @(negedge clk);
        RegWrite      = 1'b0;
        WriteRegister = 5'd7;
        WriteData     = 64'h99;
        repeat (3) @(posedge clk);
        #1;
        set_reads(5'd7, 5'd7);
        total++;
        if (ReadData1 !== 64'h55)
            $display("FAIL we_low_x7: got %h expected 55", ReadData1);
        else passed++;
    endtask

    task automatic test_reset_collision();
        write_reg(5'd3, 64'h1234);
        @(negedge clk);
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h77;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        RegWrite = 1'b0;
        set_reads(5'd3, 5'd3);
        total++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0)
            $display("FAIL reset_collision_x3: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
        else passed++;
    endtask

    task automatic test_read_during_write();
        logic [63:0] exp_before;
`ifdef REG_FILE_BYPASS_EN
        exp_before = 64'h20;
`else
        exp_before = 64'h10;
`endif
        write_reg(5'd9, 64'h10);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd9;
        WriteData     = 64'h20;
        set_reads(5'd9, 5'd0);
        total++;
        if (ReadData1 !== exp_before)
            $display("FAIL rdw_x9_before: got %h expected %h", ReadData1, exp_before);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ReadData1 !== 64'h20)
            $display("FAIL rdw_x9_after: got %h expected 20", ReadData1);
        else passed++;
        @(negedge clk);
        WriteRegister = 5'd31;
        WriteData     = 64'h20;
        set_reads(5'd31, 5'd31);
        total++;
        if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0)
            $display("FAIL rdw_x31_before: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ReadData1 !== 64'h0)
            $display("FAIL rdw_x31_after: got %h expected 0", ReadData1);
        else passed++;
        RegWrite = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        test_pre_reset_zero();
        pulse_reset();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_write_enable_low();
        test_reset_collision();
        test_read_during_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
